// File: rtl/dr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dr_pkg: shared types, rail codes and rail-pair reductions for the         |
// |         dual-rail precharge/evaluate sequencer.                           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package dr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_EVAL  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } dr_state_t;

  localparam logic [1:0] SPACER  = 2'b00;
  localparam logic [1:0] ILLEGAL = 2'b11;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_ILLEGAL  = 2'b01;
  localparam logic [1:0] FC_EVAL_TMO = 2'b10;
  localparam logic [1:0] FC_PRE_TMO  = 2'b11;

  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Reductions accept up to MAX_PAIRS pairs; only the low w pairs are examined.
  localparam int MAX_PAIRS = 64;

  function automatic logic all_spacer(input logic [MAX_PAIRS-1:0] t,
                                      input logic [MAX_PAIRS-1:0] f,
                                      input int w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_PAIRS; i++)
      if (i < w && {t[i], f[i]} != SPACER) r = 1'b0;
    return r;
  endfunction

  function automatic logic all_complete(input logic [MAX_PAIRS-1:0] t,
                                        input logic [MAX_PAIRS-1:0] f,
                                        input int w);
    logic r;
    r = 1'b1;
    for (int i = 0; i < MAX_PAIRS; i++)
      if (i < w && ({t[i], f[i]} == SPACER || {t[i], f[i]} == ILLEGAL)) r = 1'b0;
    return r;
  endfunction

  function automatic logic any_illegal(input logic [MAX_PAIRS-1:0] t,
                                       input logic [MAX_PAIRS-1:0] f,
                                       input int w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_PAIRS; i++)
      if (i < w && {t[i], f[i]} == ILLEGAL) r = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dr_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dr_lfsr: 16-bit Galois LFSR providing the random precharge extension.     |
// |          Only instantiated when DR_RANDOM_DELAY_EN is defined.            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dr_lfsr
  import dr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [1:0] o_lfsr_low
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= LFSR_SEED;
    else if (i_en)
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  assign o_lfsr_low = r_lfsr[1:0];

endmodule
`default_nettype wire

// File: rtl/dual_rail_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dual_rail_phase_ctrl: precharge/evaluate sequencer for a dual-rail masked |
// |   datapath with completion detection and sticky fault reporting.          |
// |   Optional macro DR_RANDOM_DELAY_EN adds a random 0..3 cycle PRE stretch. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module dual_rail_phase_ctrl
  import dr_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int OUT_W      = 8,
  parameter int PRE_CYCLES = 2,
  parameter int TMO_MAX    = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic [IN_W-1:0]  dr_t,
  output logic [IN_W-1:0]  dr_f,
  input  logic [OUT_W-1:0] res_t,
  input  logic [OUT_W-1:0] res_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             fault,
  output logic [1:0]       fault_code,
  input  logic             fault_clr
);

  localparam int c_PRE_MIN = PRE_CYCLES - 1;
  localparam int c_TMO_LIM = TMO_MAX - 1;

  dr_state_t        r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [IN_W-1:0]  r_op;
  logic [OUT_W-1:0] r_out_data, w_data_nxt;
  logic [1:0]       r_fault_code, w_code_nxt;
  logic [IN_W-1:0]  r_dr_t, r_dr_f;
  logic             r_out_valid, r_fault;
  logic             w_accept, w_spacer, w_complete, w_illegal;
  logic             w_pre_done, w_pre_tmo, w_eval_tmo, w_drive;
  logic [1:0]       w_extra;
  int               w_extra_i;

`ifdef DR_RANDOM_DELAY_EN
  logic [1:0] w_lfsr_low;
  logic [1:0] r_extra;

  dr_lfsr u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (1'b1),
    .o_lfsr_low (w_lfsr_low)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_extra <= 2'd0;
    else if (w_accept) r_extra <= w_lfsr_low;
  end

  assign w_extra = r_extra;
`else
  assign w_extra = 2'd0;
`endif

  assign w_extra_i  = int'(w_extra);
  assign w_spacer   = all_spacer(MAX_PAIRS'(res_t), MAX_PAIRS'(res_f), OUT_W);
  assign w_complete = all_complete(MAX_PAIRS'(res_t), MAX_PAIRS'(res_f), OUT_W);
  assign w_illegal  = any_illegal(MAX_PAIRS'(res_t), MAX_PAIRS'(res_f), OUT_W);
  assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_pre_done = w_spacer && (int'(r_cnt) >= c_PRE_MIN + w_extra_i);
  assign w_pre_tmo  = int'(r_cnt) >= c_TMO_LIM + w_extra_i;
  assign w_eval_tmo = int'(r_cnt) >= c_TMO_LIM;

  // Illegal codes outrank timeouts, which outrank normal advance.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_fault_code;
    w_data_nxt  = r_out_data;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_PRE;
        end
      end
      ST_PRE: begin
        if (w_illegal) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_ILLEGAL;
        end else if (!w_pre_done && w_pre_tmo) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_PRE_TMO;
        end else if (w_pre_done) begin
          w_state_nxt = ST_EVAL;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_EVAL: begin
        if (w_illegal) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_ILLEGAL;
        end else if (!w_complete && w_eval_tmo) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_EVAL_TMO;
        end else if (w_complete) begin
          w_state_nxt = ST_HOLD;
          w_data_nxt  = res_t;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      ST_HOLD: begin
        if (w_illegal) begin
          w_state_nxt = ST_FAULT;
          w_code_nxt  = FC_ILLEGAL;
        end else if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          w_state_nxt = ST_IDLE;
          w_code_nxt  = FC_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so rails change with the state.
  assign w_drive = (w_state_nxt == ST_EVAL) || (w_state_nxt == ST_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_op         <= '0;
      r_out_data   <= '0;
      r_fault_code <= FC_NONE;
      r_dr_t       <= '0;
      r_dr_f       <= '0;
      r_out_valid  <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_out_data   <= w_data_nxt;
      r_fault_code <= w_code_nxt;
      if (w_accept) r_op <= in_data;
      r_dr_t       <= w_drive ? r_op  : '0;
      r_dr_f       <= w_drive ? ~r_op : '0;
      r_out_valid  <= (w_state_nxt == ST_HOLD);
      r_fault      <= (w_state_nxt == ST_FAULT);
    end
  end

  assign in_ready   = (r_state == ST_IDLE);
  assign dr_t       = r_dr_t;
  assign dr_f       = r_dr_f;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_dual_rail_phase_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dual_rail_phase_ctrl: scoreboard bench with a 1-cycle dual-rail buffer |
// |   standing in for the datapath, plus fault injection on the result rails. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_dual_rail_phase_ctrl;

  localparam int PRE = 2;
  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, fault_clr = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [7:0] dr_t, dr_f, res_t, res_f, out_data;
  logic       in_ready, out_valid, fault;
  logic [1:0] fault_code;
  logic [7:0] hold_mask = 8'h00, set_t = 8'h00, set_f = 8'h00;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat_seen = 0;
  logic [7:0] sb[$];

  dual_rail_phase_ctrl #(.IN_W(8), .OUT_W(8), .PRE_CYCLES(PRE), .TMO_MAX(TMO)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dr_t(dr_t), .dr_f(dr_f), .res_t(res_t), .res_f(res_f), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fault(fault), .fault_code(fault_code),
    .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  // Datapath model: one-cycle dual-rail buffer with stuck/forced rail injection.
  always @(posedge clk) begin
    res_t <= (dr_t & ~hold_mask) | set_t;
    res_f <= (dr_f & ~hold_mask) | set_f;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_token(output int lat);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (dr_t != 8'h00 || dr_f != 8'h00) lat = c;
    end
    if (lat == 0) chk("token_seen", 32'({dr_t, dr_f}), 32'hFFFF);
  endtask

  task automatic run_txn(input logic [7:0] d, input int stall);
    int tok_lat;
    int out_lat;
    logic [7:0] exp;
    tok_lat = 0;
    out_lat = 0;
    issue(d);
    sb.push_back(d);
    for (int c = 1; c <= 40 && out_lat == 0; c++) begin
      @(negedge clk);
      if (tok_lat == 0 && (dr_t != 8'h00 || dr_f != 8'h00)) begin
        tok_lat = c;
        chk("token_rails", 32'({dr_t, dr_f}), 32'({d, ~d}));
      end
      if (out_valid) out_lat = c;
    end
    if (out_lat == 0) begin
      chk("out_valid_seen", 32'(out_valid), 32'd1);
      void'(sb.pop_front());
    end else begin
`ifdef DR_RANDOM_DELAY_EN
      chk("pre_len_range", 32'(tok_lat >= PRE + 1 && tok_lat <= PRE + 4), 32'd1);
      if (tok_lat < 31) lat_seen |= (1 << tok_lat);
`else
      chk("token_latency", 32'(tok_lat), 32'(PRE + 1));
`endif
      chk("result_latency", 32'(out_lat), 32'(tok_lat + 2));
      repeat (stall) begin
        chk("hold_stable", 32'({out_valid, in_ready, dr_t, out_data}), 32'({1'b1, 1'b0, d, d}));
        @(negedge clk);
      end
      out_ready = 1'b1;
      exp = sb.pop_front();
      chk("sb_data", 32'({out_valid, out_data}), 32'({1'b1, exp}));
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("return_idle", 32'({in_ready, out_valid, dr_t, dr_f}), 32'({1'b1, 1'b0, 16'h0000}));
    end
  endtask

  task automatic wait_fault(input int max, output int lat);
    lat = 0;
    for (int c = 1; c <= max && lat == 0; c++) begin
      @(negedge clk);
      if (fault) lat = c;
    end
    if (lat == 0) chk("fault_seen", 32'(fault), 32'd1);
  endtask

  task automatic clear_fault(input logic [1:0] code);
    @(negedge clk);
    chk("fault_held", 32'({fault, fault_code, in_ready}), 32'({1'b1, code, 1'b0}));
    fault_clr = 1'b1;
    @(posedge clk);
    #1 fault_clr = 1'b0;
    @(negedge clk);
    chk("fault_cleared", 32'({in_ready, fault, fault_code}), 32'({1'b1, 1'b0, 2'b00}));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_rails", 32'({dr_t, dr_f}), 32'h0000);
    chk("rst_handshake", 32'({in_ready, out_valid}), 32'({1'b1, 1'b0}));
    chk("rst_out_data", 32'(out_data), 32'h00);
    chk("rst_fault", 32'({fault, fault_code}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

`ifdef DR_RANDOM_DELAY_EN
    for (int i = 0; i < 64; i++) run_txn(8'($urandom), (i % 8 == 0) ? 3 : 0);
    chk("pre_len_varies", 32'($countones(lat_seen) > 1), 32'd1);
`else
    run_txn(8'hA5, 10);
    run_txn(8'h00, 0);
    run_txn(8'hFF, 2);
    for (int i = 0; i < 4; i++) run_txn(8'($urandom), i);
    run_txn(8'h3C, 0);
`endif

    // Illegal 11 on pair 3 during EVAL, coinciding with completion of the rest.
    issue(8'h69);
    wait_token(lat);
    set_t[3] = 1'b1;
    set_f[3] = 1'b1;
    @(negedge clk);
    chk("no_fault_before_edge", 32'(fault), 32'd0);
    @(negedge clk);
    chk("illegal_fault", 32'({fault, fault_code, in_ready, out_valid}), 32'({1'b1, 2'b01, 1'b0, 1'b0}));
    chk("illegal_rails", 32'({dr_t, dr_f}), 32'h0000);
    set_t = 8'h00;
    set_f = 8'h00;
    clear_fault(2'b01);

    // Pair 0 never completes in EVAL.
    hold_mask = 8'h01;
    issue(8'h5A);
    wait_fault(60, lat);
`ifdef DR_RANDOM_DELAY_EN
    chk("eval_tmo_range", 32'(lat >= PRE + 1 + TMO && lat <= PRE + 4 + TMO), 32'd1);
`else
    chk("eval_tmo_latency", 32'(lat), 32'(PRE + 1 + TMO));
`endif
    chk("eval_tmo_code", 32'(fault_code), 32'h2);
    hold_mask = 8'h00;
    clear_fault(2'b10);

    // Pair 0 never returns to spacer in PRE.
    set_t = 8'h01;
    issue(8'h81);
    wait_fault(60, lat);
`ifdef DR_RANDOM_DELAY_EN
    chk("pre_tmo_range", 32'(lat >= 1 + TMO && lat <= 4 + TMO), 32'd1);
`else
    chk("pre_tmo_latency", 32'(lat), 32'(1 + TMO));
`endif
    chk("pre_tmo_code", 32'({fault_code, dr_t, dr_f}), 32'({2'b11, 16'h0000}));
    set_t = 8'h00;
    clear_fault(2'b11);

    // Asynchronous reset while the token is on the rails.
    issue(8'hC3);
    wait_token(lat);
    chk("mid_eval_token", 32'(dr_t), 32'hC3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rails", 32'({dr_t, dr_f}), 32'h0000);
    chk("async_rst_ctrl", 32'({in_ready, out_valid, fault, fault_code}), 32'({1'b1, 1'b0, 1'b0, 2'b00}));
    chk("async_rst_data", 32'(out_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(8'h96, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
